// File: rtl/bmu_soft_pipe.sv
// -----------------------------------------------------------------------------
// bmu_soft_pipe
//
// Pipelined soft-decision branch metric unit. Each accepted symbol carries
// N_OUT soft values of Q bits (0 = confident '0', 2^Q-1 = confident '1') and a
// per-value erasure mask. The unit produces one metric per codeword hypothesis
// c = 0..2^N_OUT-1, where bit j of c is the expected value of received value j.
// With Q=1 and no erasures the metrics are plain Hamming distances.
//
// Pipeline:
//   S1 registers the per-value distances to an expected '0' and an expected '1'.
//   S2 registers the summed metrics (optionally min-normalised).
//
// Valid/ready contract on both sides: a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid must keep its data
// stable until the transfer. While out_valid_o=1 and out_ready_i=0 the outputs
// bm_o and last_o hold. in_ready_o is combinational from out_ready_i.
//
// Optional build macro:
//   BMU_MIN_NORM_EN : S2 subtracts the minimum metric from every metric, so
//                     the best hypothesis always reads 0. Same latency.
//
// Ports:
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   clr_i        synchronous flush of pipeline and symbol counter
//   in_valid_i   input symbol valid
//   in_ready_o   block can accept a symbol
//   sym_i        soft values, value j at [j*Q +: Q]
//   era_i        erasure mask, bit j = value j punctured/erased
//   last_i       end-of-frame marker travelling with the symbol
//   out_valid_o  metrics valid
//   out_ready_i  downstream accepts metrics
//   bm_o         metric for codeword c at [c*MW +: MW]
//   last_o       last_i delayed with its symbol
//   sym_cnt_o    saturating count of accepted symbols
// -----------------------------------------------------------------------------
module bmu_soft_pipe #(
    parameter int N_OUT = 2,
    parameter int Q     = 3,
    parameter int CNT_W = 16,
    localparam int NCW  = 1 << N_OUT,
    localparam int MW   = $clog2(N_OUT * ((1 << Q) - 1) + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N_OUT*Q-1:0]   sym_i,
    input  logic [N_OUT-1:0]     era_i,
    input  logic                 last_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [NCW*MW-1:0]    bm_o,
    output logic                 last_o,
    output logic [CNT_W-1:0]     sym_cnt_o
);

    // Stage 1 state: distance of each received value to an expected 0 / 1.
    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic [N_OUT*Q-1:0]   d0_q, d0_d;
    logic [N_OUT*Q-1:0]   d1_q, d1_d;

    // Stage 2 state: per-hypothesis metrics.
    logic                 s2_valid_q;
    logic                 s2_last_q;
    logic [NCW*MW-1:0]    bm_q, bm_d;
    logic [NCW*MW-1:0]    bm_raw;

    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 s1_load;
    logic                 s2_load;
    logic                 in_fire;

    // Each stage advances when it is empty or when the stage after it advances,
    // so a stall only blocks input once both stages hold data.
    assign s2_load    = !s2_valid_q || out_ready_i;
    assign s1_load    = !s1_valid_q || s2_load;
    assign in_ready_o = s1_load && !clr_i;
    assign in_fire    = in_valid_i && in_ready_o;

    // Stage 1 distances; an erased value contributes nothing to any hypothesis.
    always_comb begin
        logic [Q-1:0] r;
        r    = '0;
        d0_d = '0;
        d1_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            r = sym_i[j*Q +: Q];
            if (!era_i[j]) begin
                d0_d[j*Q +: Q] = r;
                d1_d[j*Q +: Q] = ~r;   // (2^Q-1) - r
            end
        end
    end

    // Stage 2 sums: bit j of the hypothesis index selects the distance used
    // for received value j.
    always_comb begin
        logic [MW-1:0] acc;
        acc    = '0;
        bm_raw = '0;
        for (int c = 0; c < NCW; c++) begin
            acc = '0;
            for (int j = 0; j < N_OUT; j++) begin
                if (((c >> j) & 1) != 0) begin
                    acc = acc + MW'(d1_q[j*Q +: Q]);
                end else begin
                    acc = acc + MW'(d0_q[j*Q +: Q]);
                end
            end
            bm_raw[c*MW +: MW] = acc;
        end
    end

`ifdef BMU_MIN_NORM_EN
    // Normalise against the best hypothesis within the same cycle.
    always_comb begin
        logic [MW-1:0] bm_min;
        bm_min = bm_raw[MW-1:0];
        bm_d   = '0;
        for (int c = 1; c < NCW; c++) begin
            if (bm_raw[c*MW +: MW] < bm_min) begin
                bm_min = bm_raw[c*MW +: MW];
            end
        end
        for (int c = 0; c < NCW; c++) begin
            bm_d[c*MW +: MW] = bm_raw[c*MW +: MW] - bm_min;
        end
    end
`else
    assign bm_d = bm_raw;
`endif

    // Saturating accepted-symbol counter.
    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            d0_q       <= '0;
            d1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            bm_q       <= '0;
            cnt_q      <= '0;
        end else if (clr_i) begin
            // Flush wins over any transfer in the same cycle.
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid_i;
                if (in_valid_i) begin
                    d0_q      <= d0_d;
                    d1_q      <= d1_d;
                    s1_last_q <= last_i;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    bm_q      <= bm_d;
                    s2_last_q <= s1_last_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign bm_o        = bm_q;
    assign last_o      = s2_last_q;
    assign sym_cnt_o   = cnt_q;

endmodule

// File: tb/tb_bmu_soft_pipe.sv
// -----------------------------------------------------------------------------
// tb_bmu_soft_pipe
//
// Main instance: N_OUT=2, Q=3, CNT_W=3 (MW=4). A second instance with Q=1
// covers the Hamming-distance case. Expected metrics come from ref_bm(), which
// evaluates the metric definition with integer arithmetic; in-flight symbols
// are tracked in exp_q together with the edge on which they were accepted.
// -----------------------------------------------------------------------------
module tb_bmu_soft_pipe;

    localparam int MW = 4;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  sym;
    logic [1:0]  era;
    logic        last_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bm;
    logic        last_o;
    logic [2:0]  cnt;

    logic        in_valid_h;
    logic        in_ready_h;
    logic [1:0]  sym_h;
    logic        out_valid_h;
    logic [7:0]  bm_h;
    logic        last_h;
    logic [15:0] cnt_h;

    bmu_soft_pipe #(.N_OUT(2), .Q(3), .CNT_W(3)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sym_i       (sym),
        .era_i       (era),
        .last_i      (last_i),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .bm_o        (bm),
        .last_o      (last_o),
        .sym_cnt_o   (cnt)
    );

    bmu_soft_pipe #(.N_OUT(2), .Q(1), .CNT_W(16)) dut_h (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (1'b0),
        .in_valid_i  (in_valid_h),
        .in_ready_o  (in_ready_h),
        .sym_i       (sym_h),
        .era_i       (2'b00),
        .last_i      (1'b0),
        .out_valid_o (out_valid_h),
        .out_ready_i (1'b1),
        .bm_o        (bm_h),
        .last_o      (last_h),
        .sym_cnt_o   (cnt_h)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0] bm;
        logic        last;
        int          acc_edge;
    } item_t;

    typedef struct {
        logic [5:0]  sym;
        logic [1:0]  era;
        logic [15:0] exp;
    } vec_t;

    item_t       exp_q[$];
    vec_t        tbl[6];
    int          n_chk;
    int          n_pass;
    int          edge_cnt;
    int          n_out;
    logic [2:0]  cnt_model;
    logic        stall_prev;
    logic [15:0] bm_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Subtract the smallest of the four metrics when normalisation is built.
    function automatic logic [15:0] norm(input logic [15:0] v);
        logic [15:0] res;
        res = v;
`ifdef BMU_MIN_NORM_EN
        begin
            int m[4];
            int mn;
            for (int c = 0; c < 4; c++) m[c] = int'(v[c*4 +: 4]);
            mn = m[0];
            for (int c = 1; c < 4; c++) if (m[c] < mn) mn = m[c];
            for (int c = 0; c < 4; c++) res[c*4 +: 4] = 4'(m[c] - mn);
        end
`endif
        return res;
    endfunction

    // Metric definition: sum over values of |expected*7 - r|, erased values skipped.
    function automatic logic [15:0] ref_bm(input logic [5:0] s, input logic [1:0] e);
        logic [15:0] res;
        int m;
        int r;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            m = 0;
            for (int j = 0; j < 2; j++) begin
                r = int'(s[j*3 +: 3]);
                if (!e[j]) m += (((c >> j) & 1) != 0) ? (7 - r) : r;
            end
            res[c*4 +: 4] = 4'(m);
        end
        return norm(res);
    endfunction

    // ---------------- driver: one cycle with model checks ----------------
    task automatic step(input logic v, input logic [5:0] s, input logic [1:0] e,
                        input logic l, input logic ordy, input logic c);
        logic  acc;
        logic  ox;
        logic  exp_rdy;
        logic  exp_ov;
        item_t it;
        @(negedge clk);
        in_valid  = v;
        sym       = s;
        era       = e;
        last_i    = l;
        out_ready = ordy;
        clr       = c;
        #1;
        exp_rdy = !c && !(exp_q.size() == 2 && !ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        exp_ov = (exp_q.size() > 0) && (exp_q[0].acc_edge < edge_cnt);
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (out_valid && exp_q.size() > 0) begin
            chk("bm", 32'(bm), 32'(exp_q[0].bm));
            chk("last", 32'(last_o), 32'(exp_q[0].last));
        end
        if (stall_prev) chk("bm_hold", 32'(bm), 32'(bm_prev));
        chk("sym_cnt", 32'(cnt), 32'(cnt_model));
        acc        = v && in_ready;
        ox         = out_valid && ordy;
        stall_prev = out_valid && !ordy && !c;
        bm_prev    = bm;
        @(posedge clk);
        edge_cnt++;
        if (c) begin
            exp_q.delete();
            cnt_model = '0;
        end else begin
            if (ox && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                n_out++;
            end
            if (acc) begin
                it.bm       = ref_bm(s, e);
                it.last     = l;
                it.acc_edge = edge_cnt;
                exp_q.push_back(it);
                if (cnt_model != 3'd7) cnt_model = cnt_model + 3'd1;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) step(1'b0, 6'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        logic pat[4];
        logic [5:0] y;

        tbl[0] = '{sym: {3'd7, 3'd2}, era: 2'b00, exp: {4'd5, 4'd2, 4'd12, 4'd9}};
        tbl[1] = '{sym: {3'd7, 3'd2}, era: 2'b10, exp: {4'd5, 4'd2, 4'd5, 4'd2}};
        tbl[2] = '{sym: {3'd0, 3'd0}, era: 2'b00, exp: {4'd14, 4'd7, 4'd7, 4'd0}};
        tbl[3] = '{sym: {3'd3, 3'd5}, era: 2'b01, exp: {4'd4, 4'd4, 4'd3, 4'd3}};
        tbl[4] = '{sym: {3'd6, 3'd1}, era: 2'b11, exp: 16'd0};
        tbl[5] = '{sym: {3'd7, 3'd7}, era: 2'b00, exp: {4'd0, 4'd7, 4'd7, 4'd14}};

        n_chk = 0; n_pass = 0; edge_cnt = 0; n_out = 0;
        cnt_model = '0; stall_prev = 1'b0; bm_prev = '0;
        clr = 1'b0; in_valid = 1'b0; sym = '0; era = '0; last_i = 1'b0; out_ready = 1'b1;
        in_valid_h = 1'b0; sym_h = '0;

        // Reset values while reset is held.
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bm", 32'(bm), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Table vectors, one at a time with out_ready held high.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, tbl[i].sym, tbl[i].era, 1'(i & 1), 1'b1, 1'b0);
            step(1'b0, 6'd0, 2'b00, 1'b0, 1'b1, 1'b0);
            #2;
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_bm", 32'(bm), 32'(norm(tbl[i].exp)));
            drain();
        end

        // Q=1 instance: Hamming distances (min is already 0 for both symbols).
        @(negedge clk); in_valid_h = 1'b1; sym_h = 2'b11;
        @(negedge clk); sym_h = 2'b01;
        @(negedge clk); in_valid_h = 1'b0;
        #1;
        chk("ham_valid0", 32'(out_valid_h), 32'd1);
        chk("ham_bm0", 32'(bm_h), 32'({2'd0, 2'd1, 2'd1, 2'd2}));
        @(negedge clk); #1;
        chk("ham_valid1", 32'(out_valid_h), 32'd1);
        chk("ham_bm1", 32'(bm_h), 32'({2'd1, 2'd2, 2'd0, 2'd1}));

        // Back-to-back stream under periodic backpressure.
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        n_out = 0;
        begin
            int sent;
            int cyc;
            sent = 0;
            cyc  = 0;
            while ((sent < 8 || exp_q.size() > 0) && cyc < 80) begin
                if (sent < 8) begin
                    step(1'b1, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                         1'(sent == 7), pat[cyc % 4], 1'b0);
                    if (exp_q.size() > 0 && exp_q[exp_q.size()-1].acc_edge == edge_cnt) sent++;
                end else begin
                    step(1'b0, 6'd0, 2'b00, 1'b0, pat[cyc % 4], 1'b0);
                end
                cyc++;
            end
            chk("stream_sent", 32'(sent), 32'd8);
            chk("stream_delivered", 32'(n_out), 32'd8);
        end

        // Flush with both stages full and a symbol presented.
        step(1'b1, 6'd11, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd22, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd33, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd44, 2'b00, 1'b0, 1'b0, 1'b1);
        #2;
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_cnt", 32'(cnt), 32'd0);
        y = {3'd7, 3'd2};
        step(1'b1, y, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b0, 6'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        #2;
        chk("clr_next_valid", 32'(out_valid), 32'd1);
        chk("clr_next_bm", 32'(bm), 32'(ref_bm(y, 2'b00)));
        chk("clr_next_cnt", 32'(cnt), 32'd1);
        drain();

        // Counter saturation at 2^3-1.
        for (int i = 0; i < 10; i++) step(1'b1, 6'($urandom_range(0, 63)), 2'b00, 1'b0, 1'b1, 1'b0);
        #2;
        chk("cnt_sat", 32'(cnt), 32'd7);
        drain();

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        drain();

        // Asynchronous reset in mid-stream.
        step(1'b1, {3'd7, 3'd2}, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b1, {3'd0, 3'd5}, 2'b00, 1'b1, 1'b1, 1'b0);
        #2;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_bm", 32'(bm), 32'd0);
        chk("arst_last", 32'(last_o), 32'd0);
        chk("arst_cnt", 32'(cnt), 32'd0);
        exp_q.delete();
        cnt_model  = '0;
        stall_prev = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
